// File: rtl/mem_access_unit_if.sv
// Data-memory bus between mem_access_unit (master) and the data memory (slave).
// The unit drives strobes, address, data and byte enables; the memory answers with resp/rdata.
interface mem_access_unit_if;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_address;
   logic [15:0] mem_wdata;
   logic [1:0]  mem_byte_enable;
   logic        mem_resp;
   logic [15:0] mem_rdata;

   modport master (
      output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
      input  mem_resp, mem_rdata
   );

   modport slave (
      input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
      output mem_resp, mem_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access sequencer: word/byte loads and stores plus pointer-indirect LDI/STI.
// Define MEM_ACCESS_TIMEOUT_EN to abort after TIMEOUT_CYCLES silent memory cycles (err pulse).
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                valid_in,
   input  logic [2:0]          mem_op,
   input  logic [15:0]         addr_in,
   input  logic [15:0]         wdata_in,
   mem_access_unit_if.master   bus,
   output logic                stall,
   output logic                done,
   output logic [15:0]         mdr_out,
   output logic [15:0]         mar_out,
   output logic                err
);
   localparam int DATA_W = 16;

   localparam logic [2:0] OP_LDR = 3'b001;
   localparam logic [2:0] OP_LDB = 3'b010;
   localparam logic [2:0] OP_STR = 3'b011;
   localparam logic [2:0] OP_STB = 3'b100;
   localparam logic [2:0] OP_LDI = 3'b101;
   localparam logic [2:0] OP_STI = 3'b110;

   typedef enum logic [1:0] {IDLE, PTR, ACCESS} state_t;

   state_t              state;
   logic [2:0]          op_q;
   logic [DATA_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   mdr_q;
   logic [DATA_W-1:0]   mar_q;

   logic                op_valid;
   logic                accept;
   logic                resp_ptr;
   logic                resp_acc;
   logic                tmo_hit;
   logic [DATA_W-1:0]   load_val;

   function automatic logic is_load(input logic [2:0] op);
      return (op == OP_LDR) || (op == OP_LDB) || (op == OP_LDI);
   endfunction

   function automatic logic is_byte(input logic [2:0] op);
      return (op == OP_LDB) || (op == OP_STB);
   endfunction

   function automatic logic [DATA_W-1:0] load_data(input logic [2:0] op, input logic hi,
                                                   input logic [DATA_W-1:0] rd);
      if (op == OP_LDB)
         return hi ? {8'h00, rd[15:8]} : {8'h00, rd[7:0]};
      return rd;
   endfunction

   function automatic logic [DATA_W-1:0] store_data(input logic [2:0] op,
                                                    input logic [DATA_W-1:0] wd);
      // Byte stores replicate the byte so either lane enable picks it up.
      if (op == OP_STB)
         return {wd[7:0], wd[7:0]};
      return wd;
   endfunction

   assign op_valid = (mem_op != 3'b000) && (mem_op != 3'b111);
   assign accept   = (state == IDLE) && valid_in && op_valid;
   assign resp_ptr = (state == PTR) && bus.mem_resp;
   assign resp_acc = (state == ACCESS) && bus.mem_resp;
   assign load_val = load_data(op_q, addr_q[0], bus.mem_rdata);

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_cnt;

   assign tmo_hit = (state != IDLE) && !bus.mem_resp &&
                    (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   // Never fires: this build waits on the memory indefinitely.
   assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

   assign err   = tmo_hit;
   assign done  = resp_acc || tmo_hit;
   assign stall = accept || ((state != IDLE) && !done);

   // Bus outputs decode registered state only; nothing from the pipeline side leaks through.
   assign bus.mem_read        = (state == PTR) || ((state == ACCESS) && is_load(op_q));
   assign bus.mem_write       = (state == ACCESS) && !is_load(op_q);
   assign bus.mem_address     = {addr_q[DATA_W-1:1], 1'b0};
   assign bus.mem_wdata       = store_data(op_q, wdata_q);
   assign bus.mem_byte_enable = (state == IDLE) ? 2'b00 :
                                ((state == ACCESS) && is_byte(op_q)) ?
                                   (addr_q[0] ? 2'b10 : 2'b01) : 2'b11;

   always_comb begin
      mdr_out = mdr_q;
      if (tmo_hit)
         mdr_out = '0;
      else if (resp_acc && is_load(op_q))
         mdr_out = load_val;
   end

   assign mar_out = mar_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         op_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         mdr_q   <= '0;
         mar_q   <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
         tmo_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q    <= mem_op;
                  addr_q  <= addr_in;
                  wdata_q <= wdata_in;
                  mar_q   <= addr_in;
                  state   <= ((mem_op == OP_LDI) || (mem_op == OP_STI)) ? PTR : ACCESS;
               end
            end
            PTR: begin
               if (resp_ptr) begin
                  // The fetched pointer becomes the effective address for the data access.
                  addr_q <= bus.mem_rdata;
                  mar_q  <= bus.mem_rdata;
                  state  <= ACCESS;
               end else if (tmo_hit) begin
                  mdr_q <= '0;
                  state <= IDLE;
               end
            end
            ACCESS: begin
               if (resp_acc) begin
                  if (is_load(op_q))
                     mdr_q <= load_val;
                  state <= IDLE;
               end else if (tmo_hit) begin
                  mdr_q <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
`ifdef MEM_ACCESS_TIMEOUT_EN
         if ((state == IDLE) || bus.mem_resp || tmo_hit)
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + CNT_W'(1);
`endif
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a transaction-level reference model.
// Build with MEM_ACCESS_TIMEOUT_EN defined to also exercise the timeout abort (limit 4).
module tb_mem_access_unit;
`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam int TMO = 4;
`else
   localparam int TMO = 255;
`endif

   logic        clk;
   logic        rst_n;
   logic        valid_in;
   logic [2:0]  mem_op;
   logic [15:0] addr_in;
   logic [15:0] wdata_in;
   logic        stall;
   logic        done;
   logic [15:0] mdr_out;
   logic [15:0] mar_out;
   logic        err;

   mem_access_unit_if bus ();

   mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_in (valid_in),
      .mem_op   (mem_op),
      .addr_in  (addr_in),
      .wdata_in (wdata_in),
      .bus      (bus.master),
      .stall    (stall),
      .done     (done),
      .mdr_out  (mdr_out),
      .mar_out  (mar_out),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] model_mdr = 16'h0000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle with nothing acceptable presented; a stray mem_resp must be ignored.
   task automatic idle_cycle();
      valid_in      = 1'($urandom_range(0, 1));
      mem_op        = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
      addr_in       = 16'($urandom);
      bus.mem_resp  = 1'($urandom_range(0, 1));
      bus.mem_rdata = 16'($urandom);
      @(negedge clk);
      check("idle_stall", stall, 1'b0);
      check("idle_done", done, 1'b0);
      check("idle_rw", {bus.mem_read, bus.mem_write}, 2'b00);
      check("idle_mdr", mdr_out, model_mdr);
      tick();
      bus.mem_resp = 1'b0;
   endtask

   task automatic run_txn(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wd,
                          input logic [15:0] ptr, input logic [15:0] rd,
                          input int ptr_lat, input int acc_lat);
      logic        indirect, load, byte_op;
      logic [15:0] eff, exp_wd, exp_mdr;
      logic [1:0]  exp_be;
      indirect = (op == 3'b101) || (op == 3'b110);
      load     = (op == 3'b001) || (op == 3'b010) || (op == 3'b101);
      byte_op  = (op == 3'b010) || (op == 3'b100);
      eff      = indirect ? ptr : addr;
      exp_be   = !byte_op ? 2'b11 : (eff[0] ? 2'b10 : 2'b01);
      exp_wd   = (op == 3'b100) ? {wd[7:0], wd[7:0]} : wd;
      if (op == 3'b010)
         exp_mdr = eff[0] ? (rd >> 8) : (rd & 16'h00FF);
      else
         exp_mdr = rd;

      valid_in = 1'b1; mem_op = op; addr_in = addr; wdata_in = wd; bus.mem_resp = 1'b0;
      @(negedge clk);
      check("acc_stall", stall, 1'b1);
      check("acc_done", done, 1'b0);
      check("acc_rw", {bus.mem_read, bus.mem_write}, 2'b00);
      check("acc_mdr_hold", mdr_out, model_mdr);
      tick();
      valid_in = 1'b0; mem_op = 3'b000; addr_in = 16'($urandom); wdata_in = 16'($urandom);

      if (indirect) begin
         for (int i = 0; i <= ptr_lat; i++) begin
            bus.mem_resp  = (i == ptr_lat);
            bus.mem_rdata = (i == ptr_lat) ? ptr : 16'($urandom);
            @(negedge clk);
            check("ptr_rw", {bus.mem_read, bus.mem_write}, 2'b10);
            check("ptr_addr", bus.mem_address, {addr[15:1], 1'b0});
            check("ptr_be", bus.mem_byte_enable, 2'b11);
            check("ptr_stall", stall, 1'b1);
            check("ptr_done", done, 1'b0);
            tick();
         end
      end

      for (int i = 0; i <= acc_lat; i++) begin
         bus.mem_resp  = (i == acc_lat);
         bus.mem_rdata = (i == acc_lat) ? rd : 16'($urandom);
         @(negedge clk);
         check("mem_rw", {bus.mem_read, bus.mem_write}, load ? 2'b10 : 2'b01);
         check("mem_addr", bus.mem_address, {eff[15:1], 1'b0});
         check("mem_be", bus.mem_byte_enable, exp_be);
         if (!load)
            check("mem_wdata", bus.mem_wdata, exp_wd);
         check("mar", mar_out, eff);
         check("done", done, i == acc_lat);
         check("stall", stall, i != acc_lat);
         check("err", err, 1'b0);
         if (i == acc_lat) begin
            if (load)
               model_mdr = exp_mdr;
            check("mdr_done", mdr_out, model_mdr);
         end
         tick();
      end
      bus.mem_resp = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; valid_in = 1'b0; mem_op = 3'b000; addr_in = 16'h0; wdata_in = 16'h0;
      bus.mem_resp = 1'b0; bus.mem_rdata = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rw", {bus.mem_read, bus.mem_write}, 2'b00);
      check("rst_be", bus.mem_byte_enable, 2'b00);
      check("rst_addr", bus.mem_address, 16'h0);
      check("rst_wdata", bus.mem_wdata, 16'h0);
      check("rst_flags", {stall, done, err}, 3'b000);
      check("rst_mdr_mar", {mdr_out, mar_out}, 32'h0);
      rst_n = 1'b1;
      tick();

      // Directed scenarios with hand-picked values.
      run_txn(3'b001, 16'h1235, 16'h0000, 16'h0000, 16'hBEEF, 0, 3);
      check("ldr_mdr_reg", mdr_out, 16'hBEEF);
      run_txn(3'b010, 16'h2001, 16'h0000, 16'h0000, 16'hA55A, 0, 1);
      check("ldb_mdr_reg", mdr_out, 16'h00A5);
      run_txn(3'b100, 16'h3000, 16'h12CD, 16'h0000, 16'hFFFF, 0, 0);
      check("stb_mdr_kept", mdr_out, 16'h00A5);
      run_txn(3'b101, 16'h4000, 16'h0000, 16'h5002, 16'h7777, 2, 1);
      check("ldi_mar", mar_out, 16'h5002);
      check("ldi_mdr_reg", mdr_out, 16'h7777);
      idle_cycle();

      // Asynchronous reset in the middle of an access.
      valid_in = 1'b1; mem_op = 3'b001; addr_in = 16'h6666; tick();
      valid_in = 1'b0; mem_op = 3'b000; tick();
      #2 rst_n = 1'b0;
      #1;
      check("arst_rw", {bus.mem_read, bus.mem_write}, 2'b00);
      check("arst_flags", {stall, done, err}, 3'b000);
      check("arst_mdr", mdr_out, 16'h0);
      model_mdr = 16'h0;
      tick();
      rst_n = 1'b1;
      run_txn(3'b011, 16'h0101, 16'hC0DE, 16'h0000, 16'h0000, 0, 0);

`ifdef MEM_ACCESS_TIMEOUT_EN
      valid_in = 1'b1; mem_op = 3'b001; addr_in = 16'h0ABC; tick();
      valid_in = 1'b0; mem_op = 3'b000; bus.mem_resp = 1'b0;
      for (int i = 0; i < TMO; i++) begin
         @(negedge clk);
         check("tmo_done", done, i == TMO - 1);
         check("tmo_err", err, i == TMO - 1);
         check("tmo_stall", stall, i != TMO - 1);
         if (i == TMO - 1)
            check("tmo_mdr", mdr_out, 16'h0);
         tick();
      end
      model_mdr = 16'h0;
      idle_cycle();
`endif

      // Random traffic: back-to-back or separated by non-accepting cycles.
      for (int n = 0; n < 60; n++) begin
         run_txn(3'($urandom_range(1, 6)), 16'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
         for (int g = $urandom_range(0, 2); g > 0; g--)
            idle_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
